// File: rtl/board_read_arbiter_if.sv
// Signal bundle between the display/algorithm requesters, the arbiter and the colour ROM.
// The slave modport is the arbiter's view; the master modport is the requester/ROM side.
interface board_read_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_gnt;
   logic              disp_rvalid;
   logic [DATA_W-1:0] disp_rdata;

   logic              alg_req;
   logic [ADDR_W-1:0] alg_addr;
   logic              alg_gnt;
   logic              alg_rvalid;
   logic [DATA_W-1:0] alg_rdata;

   logic [ADDR_W-1:0] rom_addr;
   logic [2:0]        rom_r;
   logic [2:0]        rom_g;
   logic [1:0]        rom_b;

   modport slave (
      input  disp_req, disp_addr, alg_req, alg_addr, rom_r, rom_g, rom_b,
      output disp_gnt, disp_rvalid, disp_rdata,
      output alg_gnt, alg_rvalid, alg_rdata, rom_addr
   );

   modport master (
      output disp_req, disp_addr, alg_req, alg_addr, rom_r, rom_g, rom_b,
      input  disp_gnt, disp_rvalid, disp_rdata,
      input  alg_gnt, alg_rvalid, alg_rdata, rom_addr
   );
endinterface

// File: rtl/board_read_arbiter.sv
// Shares the 1-cycle colour ROM between display (priority) and algorithm (starvation guard).
// Latency 3 cycles accept-to-rvalid, 1 read/cycle; losers are simply not granted (no queueing).
module board_read_arbiter #(
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 8,
   parameter int ALG_MAX_WAIT = 8
) (
   input logic                 i_clk,
   input logic                 i_rst,
   board_read_arbiter_if.slave bus
);
   localparam int WCNT_W = $clog2(ALG_MAX_WAIT + 1);

   logic [WCNT_W-1:0] r_wait_cnt;
   logic              r_s1_vld;
   logic              r_s1_alg;
   logic              r_s2_vld;
   logic              r_s2_alg;

   logic              w_wait_sat;
   logic              w_alg_gnt;
   logic              w_disp_gnt;
   logic [ADDR_W-1:0] w_gnt_addr;
   logic [7:0]        w_rom_dat;

   // Algorithm wins when display is idle or once it has been denied ALG_MAX_WAIT cycles in a row.
   assign w_wait_sat = (r_wait_cnt == WCNT_W'(ALG_MAX_WAIT));
   assign w_alg_gnt  = ~i_rst & bus.alg_req & (~bus.disp_req | w_wait_sat);
   assign w_disp_gnt = ~i_rst & bus.disp_req & ~w_alg_gnt;
   assign w_gnt_addr = w_alg_gnt ? bus.alg_addr : bus.disp_addr;
   assign w_rom_dat  = {bus.rom_r, bus.rom_g, bus.rom_b};

   assign bus.alg_gnt  = w_alg_gnt;
   assign bus.disp_gnt = w_disp_gnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wait_cnt      <= '0;
         r_s1_vld        <= 1'b0;
         r_s1_alg        <= 1'b0;
         r_s2_vld        <= 1'b0;
         r_s2_alg        <= 1'b0;
         bus.rom_addr    <= '0;
         bus.disp_rvalid <= 1'b0;
         bus.disp_rdata  <= '0;
         bus.alg_rvalid  <= 1'b0;
         bus.alg_rdata   <= '0;
      end else begin
         if (bus.alg_req & ~w_alg_gnt) begin
            if (!w_wait_sat) begin
               r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end
         end else begin
            r_wait_cnt <= '0;
         end

         if (w_alg_gnt | w_disp_gnt) begin
            bus.rom_addr <= w_gnt_addr;
         end

         // Owner tag travels alongside the ROM access so returns keep accept order.
         r_s1_vld <= w_alg_gnt | w_disp_gnt;
         r_s1_alg <= w_alg_gnt;
         r_s2_vld <= r_s1_vld;
         r_s2_alg <= r_s1_alg;

         bus.disp_rvalid <= r_s2_vld & ~r_s2_alg;
         bus.alg_rvalid  <= r_s2_vld & r_s2_alg;
         if (r_s2_vld & ~r_s2_alg) begin
            bus.disp_rdata <= DATA_W'(w_rom_dat);
         end
         if (r_s2_vld & r_s2_alg) begin
            bus.alg_rdata <= DATA_W'(w_rom_dat);
         end
      end
   end
endmodule

// File: tb/tb_board_read_arbiter.sv
// Directed bench for board_read_arbiter: cycle table plus starvation sequences, with a ROM model.
`timescale 1ns/1ps
module tb_board_read_arbiter;
   localparam int ADDR_W       = 6;
   localparam int DATA_W       = 8;
   localparam int ALG_MAX_WAIT = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   board_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   board_read_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .ALG_MAX_WAIT(ALG_MAX_WAIT)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   // Colour ROM model: registered read, one cycle after rom_addr.
   logic [7:0] rom_mem [0:63];
   logic [7:0] rom_q;
   always @(posedge clk) rom_q <= rom_mem[bus.rom_addr];
   assign bus.rom_r = rom_q[7:5];
   assign bus.rom_g = rom_q[4:2];
   assign bus.rom_b = rom_q[1:0];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst;
      logic       dreq;
      logic [5:0] daddr;
      logic       areq;
      logic [5:0] aaddr;
      logic       dg;
      logic       ag;
      logic [5:0] rom;
      logic       dv;
      logic [7:0] dd;
      logic       av;
      logic [7:0] ad;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int r, input int dq, input int da, input int aq, input int aa,
                               input int dg, input int ag, input int ra,
                               input int dv, input int dd, input int av, input int ad);
      vec_t v;
      v.rst = 1'(r);   v.dreq = 1'(dq); v.daddr = 6'(da); v.areq = 1'(aq); v.aaddr = 6'(aa);
      v.dg  = 1'(dg);  v.ag   = 1'(ag); v.rom   = 6'(ra);
      v.dv  = 1'(dv);  v.dd   = 8'(dd); v.av    = 1'(av); v.ad    = 8'(ad);
      return v;
   endfunction

   task automatic drive(input logic r, input logic dq, input logic [5:0] da,
                        input logic aq, input logic [5:0] aa);
      rst           = r;
      bus.disp_req  = dq;
      bus.disp_addr = da;
      bus.alg_req   = aq;
      bus.alg_addr  = aa;
   endtask

   initial begin
      int disp_rv;
      int alg_rv;
      logic exp_ag;

      for (int i = 0; i < 64; i++) rom_mem[i] = (i < 36) ? 8'(i * 5 + 17) : 8'h00;
      rom_mem[0] = 8'h93; rom_mem[1] = 8'hAB; rom_mem[2] = 8'hC9;
      rom_mem[3] = 8'h55; rom_mem[4] = 8'hE0;

      //         rst dq da aq aa  dg ag rom  dv dd     av ad
      vecs.push_back(mk(1, 1, 5, 1, 6,  0, 0, 0,  0, 8'h00, 0, 8'h00)); // reset blocks grants
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 8'h00, 0, 8'h00));
      vecs.push_back(mk(0, 1, 4, 0, 0,  1, 0, 0,  0, 8'h00, 0, 8'h00)); // single display read
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 4,  0, 8'h00, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 4,  0, 8'h00, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 4,  1, 8'hE0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 4,  0, 8'hE0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 1, 0,  0, 1, 4,  0, 8'hE0, 0, 8'h00)); // alg burst 0,1,2
      vecs.push_back(mk(0, 0, 0, 1, 1,  0, 1, 0,  0, 8'hE0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 1, 2,  0, 1, 1,  0, 8'hE0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 2,  0, 8'hE0, 1, 8'h93));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 2,  0, 8'hE0, 1, 8'hAB));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 2,  0, 8'hE0, 1, 8'hC9));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 2,  0, 8'hE0, 0, 8'hC9));
      vecs.push_back(mk(0, 1, 3, 0, 0,  1, 0, 2,  0, 8'hE0, 0, 8'hC9)); // mixed owners back-to-back
      vecs.push_back(mk(0, 0, 0, 1, 4,  0, 1, 3,  0, 8'hE0, 0, 8'hC9));
      vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 4,  0, 8'hE0, 0, 8'hC9));
      vecs.push_back(mk(0, 1, 1, 1, 2,  1, 0, 0,  1, 8'h55, 0, 8'hC9));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1,  0, 8'h55, 1, 8'hE0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1,  1, 8'h93, 0, 8'hE0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1,  1, 8'hAB, 0, 8'hE0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1,  0, 8'hAB, 0, 8'hE0));
      vecs.push_back(mk(0, 0, 0, 1, 40, 0, 1, 1,  0, 8'hAB, 0, 8'hE0)); // out-of-board address
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 40, 0, 8'hAB, 0, 8'hE0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 40, 0, 8'hAB, 0, 8'hE0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 40, 0, 8'hAB, 1, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 40, 0, 8'hAB, 0, 8'h00));
      vecs.push_back(mk(0, 1, 2, 0, 0,  1, 0, 40, 0, 8'hAB, 0, 8'h00)); // accept then reset
      vecs.push_back(mk(1, 1, 5, 1, 6,  0, 0, 2,  0, 8'hAB, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 8'h00, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 8'h00, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 8'h00, 0, 8'h00));
      vecs.push_back(mk(0, 1, 4, 0, 0,  1, 0, 0,  0, 8'h00, 0, 8'h00)); // clean resume
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 4,  0, 8'h00, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 4,  0, 8'h00, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 4,  1, 8'hE0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 4,  0, 8'hE0, 0, 8'h00));

      drive(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].dreq, vecs[i].daddr, vecs[i].areq, vecs[i].aaddr);
         #1;
         chk($sformatf("v%0d.disp_gnt", i),    32'(bus.disp_gnt),    32'(vecs[i].dg));
         chk($sformatf("v%0d.alg_gnt", i),     32'(bus.alg_gnt),     32'(vecs[i].ag));
         chk($sformatf("v%0d.rom_addr", i),    32'(bus.rom_addr),    32'(vecs[i].rom));
         chk($sformatf("v%0d.disp_rvalid", i), 32'(bus.disp_rvalid), 32'(vecs[i].dv));
         chk($sformatf("v%0d.disp_rdata", i),  32'(bus.disp_rdata),  32'(vecs[i].dd));
         chk($sformatf("v%0d.alg_rvalid", i),  32'(bus.alg_rvalid),  32'(vecs[i].av));
         chk($sformatf("v%0d.alg_rdata", i),   32'(bus.alg_rdata),   32'(vecs[i].ad));
      end

      // Both requesters held: algorithm breaks through every ALG_MAX_WAIT+1 cycles.
      disp_rv = 0;
      alg_rv  = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (c < 20) drive(1'b0, 1'b1, 6'd1, 1'b1, 6'd2);
         else        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
         #1;
         if (c < 20) begin
            exp_ag = (c == 8) || (c == 17);
            chk($sformatf("starve%0d.alg_gnt", c),  32'(bus.alg_gnt),  32'(exp_ag));
            chk($sformatf("starve%0d.disp_gnt", c), 32'(bus.disp_gnt), 32'(!exp_ag));
         end
         if (bus.disp_rvalid) begin
            disp_rv++;
            chk($sformatf("starve%0d.disp_rdata", c), 32'(bus.disp_rdata), 32'h00AB);
         end
         if (bus.alg_rvalid) begin
            alg_rv++;
            chk($sformatf("starve%0d.alg_rdata", c), 32'(bus.alg_rdata), 32'h00C9);
         end
      end
      chk("starve.disp_rvalid_count", 32'(disp_rv), 32'd18);
      chk("starve.alg_rvalid_count",  32'(alg_rv),  32'd2);

      // Dropping alg_req for one cycle restarts the wait count.
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 6'd3, (c != 5), 6'd0);
         #1;
         exp_ag = (c == 14);
         chk($sformatf("drop%0d.alg_gnt", c),  32'(bus.alg_gnt),  32'(exp_ag));
         chk($sformatf("drop%0d.disp_gnt", c), 32'(bus.disp_gnt), 32'(!exp_ag));
      end

      @(negedge clk);
      drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      repeat (5) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
